// File: rtl/rw_deframer_pkg.sv
// rw_deframer_pkg: shared FSM state type and default sizing for the bit deframer
package rw_deframer_pkg;
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/rw_sync_fifo.sv
// rw_sync_fifo: register-based FIFO where a full FIFO still accepts a push when popped on the same edge
module rw_sync_fifo
    import rw_deframer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    // storage, wrapping pointers and occupancy; reset empties and zeroes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/rw_bit_deframer.sv
// rw_bit_deframer: turns start/data/stop serial frames into words queued in an output FIFO
module rw_bit_deframer
    import rw_deframer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             clr_err,
    output logic             overflow,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   sh;
    logic               push, pop, full, empty, drop;
    logic [$clog2(DEPTH):0] count;

    assign push    = state == STOP && in_valid && !in_bit;
    assign pop     = m_ready && !empty;
    assign drop    = push && full && !pop;
    assign m_valid = count != '0;

    // framing FSM: a 1 starts a frame, WIDTH bits are captured LSB-first, a 0 stop bit completes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            frame_err <= 1'b0;
        end else begin
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        state <= in_bit ? DATA : IDLE;
                    end
                    DATA: begin
                        sh[cnt] <= in_bit;
                        cnt     <= cnt + 1'b1;
                        state   <= cnt == CW'(WIDTH-1) ? STOP : DATA;
                    end
                    default: state <= IDLE;
                endcase
            end
            frame_err <= (state == STOP && in_valid && in_bit) ? 1'b1 : clr_err ? 1'b0 : frame_err;
        end
    end

    // sticky overflow: a completed word found no room; a fresh drop beats a clear on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow <= 1'b0;
        else     overflow <= drop ? 1'b1 : clr_err ? 1'b0 : overflow;
    end

    rw_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (sh),
        .full  (full),
        .pop   (pop),
        .rdata (m_data),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_rw_bit_deframer.sv
// tb_rw_bit_deframer: directed table and sequence checks of framing, FIFO order, errors and reset
module tb_rw_bit_deframer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic       overflow;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    rw_bit_deframer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .clr_err   (clr_err),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic b, input logic v);
        @(negedge clk);
        in_bit   = b;
        in_valid = v;
    endtask

    // returns at the negedge just after the stop-bit edge, with in_valid low
    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap,
                              input logic rs, input logic cs);
        tick(1'b1, 1'b1);
        for (int g = 0; g < gap; g++) tick(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(d[i], 1'b1);
            for (int g = 0; g < gap; g++) tick(1'b0, 1'b0);
        end
        tick(stop, 1'b1);
        m_ready = rs;
        clr_err = cs;
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        m_ready  = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h01, 1'b0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);
        rst = 1'b0;

        m_ready = 1'b1;
        repeat (3) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) tick(i % 2 == 0 ? ((8'hA5 >> i) & 1) != 0 : ((8'hA5 >> i) & 1) != 0, 1'b1);
        tick(1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("a5_valid", m_valid, 1);
        check("a5_data", m_data, 8'hA5);
        @(negedge clk);
        check("a5_one_cycle", m_valid, 0);
        m_ready = 1'b0;

        for (int k = 0; k < 7; k++) begin
            send_frame(vecs[k].data, vecs[k].stop, 0, 1'b0, 1'b0);
            check($sformatf("tab%0d_valid", k), m_valid, vecs[k].exp_valid);
            if (vecs[k].exp_valid) check($sformatf("tab%0d_data", k), m_data, vecs[k].data);
            check($sformatf("tab%0d_ferr", k), frame_err, vecs[k].exp_ferr);
            pop_one();
            check($sformatf("tab%0d_drained", k), m_valid, 0);
            clear_flags();
            check($sformatf("tab%0d_ferr_clr", k), frame_err, 0);
        end

        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b0, 0, 1'b0, 1'b0);
            if (k == 4) check("ovf_before", overflow, 0);
        end
        check("ovf_after5", overflow, 1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d_valid", k), m_valid, 1);
            check($sformatf("drain%0d_data", k), m_data, k);
            pop_one();
        end
        check("drain_empty", m_valid, 0);
        clear_flags();
        check("ovf_clr", overflow, 0);

        send_frame(8'h11, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 0, 1'b1, 1'b0);
        check("fullpp_ovf", overflow, 0);
        check("fullpp_head", m_data, 8'h22);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("fullpp%0d_valid", k), m_valid, 1);
            check($sformatf("fullpp%0d_data", k), m_data, k * 8'h11);
            pop_one();
        end
        check("fullpp_empty", m_valid, 0);

        send_frame(8'hA5, 1'b0, 1, 1'b0, 1'b0);
        check("gap_valid", m_valid, 1);
        check("gap_data", m_data, 8'hA5);
        check("gap_ferr", frame_err, 0);
        check("gap_ovf", overflow, 0);
        pop_one();

        send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b1);
        check("err_wins_clr", frame_err, 1);
        clear_flags();
        check("err_cleared", frame_err, 0);

        send_frame(8'h77, 1'b0, 0, 1'b0, 1'b0);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", m_valid, 0);
        check("midrst_data", m_data, 0);
        rst = 1'b0;
        send_frame(8'h5A, 1'b0, 0, 1'b0, 1'b0);
        check("post_rst_valid", m_valid, 1);
        check("post_rst_data", m_data, 8'h5A);
        pop_one();
        check("post_rst_only", m_valid, 0);
        check("post_rst_ferr", frame_err, 0);
        check("post_rst_ovf", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
